matmul_seq_ctrl: RTL and testbench

MATMUL_SEQ_CTRL -- requirements
Module: matmul_seq_ctrl

---
 rtl/matmul_pkg.sv | 21 ++
 rtl/matmul_mac.sv | 31 +++
 rtl/matmul_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_matmul_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and sizing for the 4x4 matrix-multiply sequencer.
package matmul_pkg;

    localparam int MM_DW = 8;
    localparam int MM_N  = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    // Sum of four DW x DW products needs two extra bits over the product width.
    function automatic int mm_res_w(input int dw);
        return 2 * dw + 2;
    endfunction

    localparam int MM_RW = mm_res_w(MM_DW);

endpackage

// File: rtl/matmul_mac.sv
// Single-multiplier MAC: o_sum is the running total including this cycle's product.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int DW = MM_DW,
    parameter int RW = mm_res_w(DW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic          i_clr,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [RW-1:0] o_sum
);

    logic [2*DW-1:0] w_prod;
    logic [RW-1:0]   r_acc;

    assign w_prod = i_a * i_b;
    assign o_sum  = (i_clr ? '0 : r_acc) + RW'(w_prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_sum;
        end
    end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Loads A and B over a valid/ready stream, computes Y = A*B one MAC per cycle,
// then drains the 16 results in index order.
//   state     | meaning
//   S_IDLE    | waiting for start
//   S_LOAD    | accepting 32 beats: A row-major, then B row-major
//   S_COMPUTE | 64 MAC cycles, loop order i, j, k (k innermost)
//   S_DRAIN   | presenting results idx 0..15 on the output handshake
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int DW = MM_DW,
    parameter int N  = MM_N
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [mm_res_w(DW)-1:0] out_data,
    output logic [3:0]             out_idx,
    output logic                   busy,
    output logic                   done
);

    localparam int RW = mm_res_w(DW);
    localparam int NE = N * N;
    localparam logic [4:0] LD_LAST  = 5'(2 * NE - 1);
    localparam logic [5:0] MAC_LAST = 6'(NE * N - 1);
    localparam logic [3:0] OUT_LAST = 4'(NE - 1);

    state_t          r_state, w_next;
    logic [4:0]      r_ld_cnt;
    logic [5:0]      r_mac_cnt;
    logic [3:0]      r_out_cnt;
    logic            r_done;
    logic [DW-1:0]   r_mat_a [NE];
    logic [DW-1:0]   r_mat_b [NE];
    logic [RW-1:0]   r_res   [NE];

    logic            w_in_fire, w_out_fire, w_mac_en, w_mac_clr;
    logic [1:0]      w_i, w_j, w_k;
    logic [RW-1:0]   w_mac_sum;

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_i        = r_mac_cnt[5:4];
    assign w_j        = r_mac_cnt[3:2];
    assign w_k        = r_mac_cnt[1:0];
    assign w_mac_en   = (r_state == S_COMPUTE) && !abort;
    assign w_mac_clr  = (w_k == 2'd0);

    matmul_mac #(.DW(DW), .RW(RW)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_mac_en),
        .i_clr (w_mac_clr),
        .i_a   (r_mat_a[{w_i, w_k}]),
        .i_b   (r_mat_b[{w_k, w_j}]),
        .o_sum (w_mac_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (w_in_fire && r_ld_cnt == LD_LAST) w_next = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (r_mac_cnt == MAC_LAST) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (w_out_fire && r_out_cnt == OUT_LAST) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    assign out_data = out_valid ? r_res[r_out_cnt] : '0;
    assign out_idx  = out_valid ? r_out_cnt : '0;
    assign done     = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_cnt  <= '0;
            r_mac_cnt <= '0;
            r_out_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == S_DRAIN) && w_out_fire && (r_out_cnt == OUT_LAST) && !abort;
            if (abort || r_state == S_IDLE) begin
                r_ld_cnt  <= '0;
                r_mac_cnt <= '0;
                r_out_cnt <= '0;
            end else begin
                // Each counter wraps to zero exactly as its phase completes.
                if (w_in_fire)               r_ld_cnt  <= r_ld_cnt + 5'd1;
                if (r_state == S_COMPUTE)    r_mac_cnt <= r_mac_cnt + 6'd1;
                if (w_out_fire)              r_out_cnt <= r_out_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_fire && !abort) begin
            if (r_ld_cnt[4]) r_mat_b[r_ld_cnt[3:0]] <= in_data;
            else             r_mat_a[r_ld_cnt[3:0]] <= in_data;
        end
        if (w_mac_en && w_k == 2'd3) begin
            r_res[{w_i, w_j}] <= w_mac_sum;
        end
    end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Self-checking bench: directed job table, randomized jobs against a plain
// arithmetic matrix-product model, and reset/abort corner sequences.
module tb_matmul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, in_valid, in_ready;
    logic        out_valid, out_ready, busy, done;
    logic [7:0]  in_data;
    logic [17:0] out_data;
    logic [3:0]  out_idx;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0][7:0]  a;
        logic [15:0][7:0]  b;
        logic [15:0][17:0] ye;
        int                gap;
        int                rmode;
        bit                start_mid;
    } vec_t;

    vec_t vecs[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    matmul_seq_ctrl #(.DW(8), .N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [15:0][17:0] ref_mm(input logic [15:0][7:0] a, input logic [15:0][7:0] b);
        logic [15:0][17:0] y;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                int s = 0;
                for (int k = 0; k < 4; k++) s += int'(a[i*4+k]) * int'(b[k*4+j]);
                y[i*4+j] = 18'(s);
            end
        end
        return y;
    endfunction

    task automatic load_beats(input logic [15:0][7:0] a, input logic [15:0][7:0] b, input int gap);
        for (int beat = 0; beat < 32; beat++) begin
            if (gap > 0 && beat % 4 == 1) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            if (beat == 0) chk("in_ready_in_load", in_ready, 1);
            in_valid = 1'b1;
            in_data  = (beat < 16) ? a[beat] : b[beat-16];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Starts at a negedge; on normal completion returns at the negedge where done is high.
    task automatic run_job(input logic [15:0][7:0] a, input logic [15:0][7:0] b,
                           input logic [15:0][17:0] ye, input int gap, input int rmode,
                           input bit start_mid, input int abort_at, input bit chk_lat);
        int          t0, p, ridx, wcnt;
        bit          stalled;
        logic [17:0] held_d;
        logic [3:0]  held_i;
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_low_in_job", done, 0);
        load_beats(a, b, gap);
        chk("in_ready_after_load", in_ready, 0);
        wcnt = 0;
        while (!out_valid && wcnt < 300) begin
            start = (start_mid && wcnt == 10);
            @(negedge clk);
            wcnt++;
        end
        start = 1'b0;
        if (!out_valid) begin
            chk("first_out_valid_timeout", 0, 1);
            return;
        end
        if (chk_lat) chk("latency", cyc - t0, 97);
        ridx = 0; p = 0; wcnt = 0; stalled = 0;
        held_d = '0; held_i = '0;
        while (ridx < 16 && wcnt < 200) begin
            chk("out_valid_drain", out_valid, 1);
            if (stalled) begin
                chk("hold_data", out_data, held_d);
                chk("hold_idx", out_idx, held_i);
            end
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (p % 4 == 0) || (p % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            p++;
            if (ridx == abort_at) begin
                out_ready = 1'b1;
                abort     = 1'b1;
                @(negedge clk);
                abort     = 1'b0;
                out_ready = 1'b0;
                chk("abort_out_valid", out_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_no_done", done, 0);
                @(negedge clk);
                chk("abort_no_done_later", done, 0);
                chk("abort_stays_idle", out_valid, 0);
                return;
            end
            if (out_ready) begin
                chk("out_data", out_data, ye[ridx]);
                chk("out_idx", out_idx, ridx);
                ridx++;
                stalled = 0;
            end else begin
                held_d  = out_data;
                held_i  = out_idx;
                stalled = 1;
            end
            @(negedge clk);
            wcnt++;
        end
        out_ready = 1'b0;
        if (ridx < 16) begin
            chk("drain_timeout", ridx, 16);
            return;
        end
        chk("done_pulse", done, 1);
        chk("idle_after_done", busy, 0);
        chk("out_valid_after_done", out_valid, 0);
    endtask

    initial begin
        logic [15:0][7:0]  ra, rb;
        logic [15:0][17:0] ry;
        int                g;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                vecs[0].a[r*4+c] = (r == c) ? 8'd1 : 8'd0;
                vecs[0].b[r*4+c] = 8'(4*r + c);
                vecs[0].ye[r*4+c] = 18'(4*r + c);
                vecs[1].a[r*4+c] = 8'd255;
                vecs[1].b[r*4+c] = 8'd255;
                vecs[1].ye[r*4+c] = 18'h3F804;
            end
        end
        vecs[0].gap = 0; vecs[0].rmode = 0; vecs[0].start_mid = 0;
        vecs[1].gap = 0; vecs[1].rmode = 1; vecs[1].start_mid = 0;
        vecs[2] = vecs[0];
        vecs[2].gap = 3; vecs[2].rmode = 1; vecs[2].start_mid = 1;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_start", busy, 0);

        for (int v = 0; v < 3; v++) begin
            run_job(vecs[v].a, vecs[v].b, vecs[v].ye, vecs[v].gap, vecs[v].rmode,
                    vecs[v].start_mid, -1, vecs[v].gap == 0);
            @(negedge clk);
            chk("done_single_pulse", done, 0);
        end

        // Back-to-back random jobs: each start coincides with the previous done.
        for (int r = 0; r < 4; r++) begin
            for (int e = 0; e < 16; e++) begin
                ra[e] = 8'($urandom_range(0, 255));
                rb[e] = 8'($urandom_range(0, 255));
            end
            ry = ref_mm(ra, rb);
            g  = (r == 0) ? 0 : int'($urandom_range(0, 2));
            run_job(ra, rb, ry, g, 2, 1'b0, -1, g == 0);
        end
        @(negedge clk);
        chk("done_single_pulse_b2b", done, 0);

        // Reset asserted in the middle of COMPUTE.
        for (int e = 0; e < 16; e++) begin
            ra[e] = 8'($urandom_range(0, 255));
            rb[e] = 8'($urandom_range(0, 255));
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        load_beats(ra, rb, 0);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_idx", out_idx, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("postrst_idle", busy, 0);
        chk("postrst_no_output", out_valid, 0);
        for (int e = 0; e < 16; e++) begin
            ra[e] = 8'($urandom_range(0, 255));
            rb[e] = 8'($urandom_range(0, 255));
        end
        ry = ref_mm(ra, rb);
        run_job(ra, rb, ry, 0, 0, 1'b0, -1, 1'b1);
        @(negedge clk);

        // Abort in DRAIN at idx 5 together with out_ready, then a clean job.
        run_job(vecs[0].a, vecs[0].b, vecs[0].ye, 0, 0, 1'b0, 5, 1'b0);
        for (int e = 0; e < 16; e++) begin
            ra[e] = 8'($urandom_range(0, 255));
            rb[e] = 8'($urandom_range(0, 255));
        end
        ry = ref_mm(ra, rb);
        run_job(ra, rb, ry, 1, 2, 1'b0, -1, 1'b0);
        @(negedge clk);
        chk("final_done_low", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
